// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// Module : uart_pkg
// Brief  : Shared types and widths for the UART receive path.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
//------------------------------------------------------------------------------
// Module : sync_fifo
// Brief  : First-word-fall-through ready/valid FIFO with occupancy count.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr_en,
    input  logic [WIDTH-1:0]           i_wr_data,
    output logic                       o_full,
    output logic                       o_drop,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_rd_valid,
    input  logic                       i_rd_ready,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int                  c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0]       c_depth = (c_aw+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_depth);
    assign w_pop   = !w_empty && i_rd_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign w_push  = i_wr_en && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_full     = w_full;
    assign o_drop     = i_wr_en && !w_push;
    assign o_rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_rd_valid = !w_empty;
    assign o_count    = r_count;

endmodule

`default_nettype wire

// File: rtl/uart_rx_buffered.sv
//------------------------------------------------------------------------------
// Module : uart_rx_buffered
// Brief  : 8N1 UART receiver with FWFT character buffer and sticky error flags.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          serial_in,
    output logic [UART_DATA_W-1:0]        data_out,
    output logic                          data_out_valid,
    input  logic                          data_out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          frame_err,
    input  logic                          clr_err
);

    localparam int                   c_symbol_edge_time = CLOCK_FREQ / BAUD_RATE;
    localparam int                   c_cnt_w            = $clog2(c_symbol_edge_time);
    localparam logic [c_cnt_w-1:0]   c_bit_last         = c_cnt_w'(c_symbol_edge_time - 1);
    localparam logic [c_cnt_w-1:0]   c_half_last        = c_cnt_w'(c_symbol_edge_time / 2 - 1);
    localparam logic [2:0]           c_last_bit_idx     = 3'(UART_DATA_W - 1);

    logic [1:0]              r_sync;
    rx_state_e               r_state;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [2:0]              r_bit_idx;
    logic [UART_DATA_W-1:0]  r_shift;
    logic                    r_overflow;
    logic                    r_frame_err;

    logic w_rx_s;
    logic w_stop_sample;
    logic w_push;
    logic w_frame_set;
    logic w_drop;
    logic w_full;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], serial_in};
        end
    end

    assign w_rx_s = r_sync[1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx_s) begin
                        r_state <= START;
                    end
                end
                // Re-check the start bit at mid-bit so short glitches are rejected
                START: begin
                    if (r_cnt == c_half_last) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= w_rx_s ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx_s, r_shift[UART_DATA_W-1:1]};
                        if (r_bit_idx == c_last_bit_idx) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt   <= '0;
                        r_state <= w_rx_s ? IDLE : BREAK;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (w_rx_s) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_stop_sample = (r_state == STOP) && (r_cnt == c_bit_last);
    assign w_push        = w_stop_sample && w_rx_s;
    assign w_frame_set   = w_stop_sample && !w_rx_s;

    sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (w_push),
        .i_wr_data  (r_shift),
        .o_full     (w_full),
        .o_drop     (w_drop),
        .o_rd_data  (data_out),
        .o_rd_valid (data_out_valid),
        .i_rd_ready (data_out_ready),
        .o_count    (fifo_count)
    );

    // A new error event wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_frame_set) begin
                r_frame_err <= 1'b1;
            end else if (clr_err) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;

    logic w_unused;
    assign w_unused = w_full;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_buffered.sv
//------------------------------------------------------------------------------
// Module : tb_uart_rx_buffered
// Brief  : Self-checking bench for uart_rx_buffered against a queue-based model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_buffered;

    localparam int CLOCK_FREQ = 50_000_000;
    localparam int BAUD_RATE  = 1_562_500;
    localparam int FIFO_DEPTH = 8;
    localparam int BIT        = CLOCK_FREQ / BAUD_RATE;

    logic       clk            = 1'b0;
    logic       rst            = 1'b0;
    logic       serial_in      = 1'b1;
    logic       data_out_ready = 1'b0;
    logic       clr_err        = 1'b0;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       frame_err;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_pops   = 0;
    logic [7:0] exp_q[$];
    logic       exp_overflow = 1'b0;
    logic       exp_frame    = 1'b0;

    always #5 clk = ~clk;

    uart_rx_buffered #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .fifo_count     (fifo_count),
        .overflow       (overflow),
        .frame_err      (frame_err),
        .clr_err        (clr_err)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every accepted pop is compared with the oldest character the model holds
    always begin
        @(negedge clk);
        #2;
        if (rst && data_out_ready && data_out_valid) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                check_value("pop_with_model_empty", {31'd0, data_out_valid}, 32'd0);
            end else begin
                check_value("pop_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic model_push(input logic [7:0] ch);
        if (exp_q.size() == FIFO_DEPTH && !data_out_ready) begin
            exp_overflow = 1'b1;
        end else begin
            exp_q.push_back(ch);
        end
    endtask

    // Frame one 8N1 character; stop_low>0 holds the stop bit low for that many bit times
    task automatic send_char(input logic [7:0] ch, input int stop_low = 0, input bit pop_on_push = 1'b0);
        serial_in = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_in = ch[i];
            repeat (BIT) @(negedge clk);
        end
        if (stop_low == 0) begin
            serial_in = 1'b1;
            repeat (BIT / 2 + 1) @(negedge clk);
            if (pop_on_push) data_out_ready = 1'b1;
            model_push(ch);
            @(negedge clk);
            if (pop_on_push) data_out_ready = 1'b0;
            repeat (BIT / 2 - 2) @(negedge clk);
        end else begin
            serial_in = 1'b0;
            repeat (BIT * stop_low) @(negedge clk);
            exp_frame = 1'b1;
            serial_in = 1'b1;
            repeat (BIT) @(negedge clk);
        end
    endtask

    task automatic drain(input string tag);
        int p0;
        int want;
        p0   = n_pops;
        want = exp_q.size();
        data_out_ready = 1'b1;
        for (int i = 0; i < 4 * FIFO_DEPTH && exp_q.size() > 0; i++) @(negedge clk);
        data_out_ready = 1'b0;
        check_value({tag, "_pops"}, n_pops - p0, want);
        @(negedge clk);
        check_value({tag, "_valid"}, {31'd0, data_out_valid}, 32'd0);
        check_value({tag, "_count"}, {28'd0, fifo_count}, 32'd0);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        exp_overflow = 1'b0;
        exp_frame    = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        check_value({tag, "_count"}, {28'd0, fifo_count}, exp_q.size());
        check_value({tag, "_valid"}, {31'd0, data_out_valid}, {31'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            check_value({tag, "_head"}, {24'd0, data_out}, {24'd0, exp_q[0]});
        end
        check_value({tag, "_overflow"}, {31'd0, overflow}, {31'd0, exp_overflow});
        check_value({tag, "_frame_err"}, {31'd0, frame_err}, {31'd0, exp_frame});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        logic [7:0] ch;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_value("reset_valid", {31'd0, data_out_valid}, 32'd0);
        check_value("reset_count", {28'd0, fifo_count}, 32'd0);
        check_value("reset_data", {24'd0, data_out}, 32'd0);
        check_value("reset_overflow", {31'd0, overflow}, 32'd0);
        check_value("reset_frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b1;
        repeat (BIT) @(negedge clk);

        send_char(8'hA5);
        check_state("single_a5");
        data_out_ready = 1'b1;
        @(negedge clk);
        data_out_ready = 1'b0;
        @(negedge clk);
        check_state("single_popped");

        p0 = n_pops;
        data_out_ready = 1'b1;
        send_char(8'h00);
        send_char(8'hFF);
        send_char(8'h3C);
        repeat (4) @(negedge clk);
        data_out_ready = 1'b0;
        check_value("b2b_pops", n_pops - p0, 32'd3);
        check_state("b2b_end");

        serial_in = 1'b0;
        repeat (10) @(negedge clk);
        serial_in = 1'b1;
        repeat (BIT * 2) @(negedge clk);
        check_state("glitch");

        send_char(8'h55, 2);
        check_state("frame_bad");
        send_char(8'h12);
        check_state("frame_next");
        drain("frame_drain");
        pulse_clr();
        check_state("frame_cleared");

        for (int i = 0; i < FIFO_DEPTH + 1; i++) send_char(8'h30 + 8'(i));
        check_state("ovf_full");
        drain("ovf_drain");
        pulse_clr();
        check_state("ovf_cleared");

        for (int i = 0; i < FIFO_DEPTH; i++) send_char(8'h60 + 8'(i));
        send_char(8'h68, 0, 1'b1);
        check_state("ovf_pop_same_cycle");
        drain("ovf2_drain");

        send_char(8'h9C);
        serial_in = 1'b0;
        repeat (BIT) @(negedge clk);
        serial_in = 1'b1;
        repeat (BIT) @(negedge clk);
        serial_in = 1'b0;
        repeat (BIT / 3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        serial_in = 1'b1;
        rst = 1'b1;
        exp_q.delete();
        exp_overflow = 1'b0;
        exp_frame    = 1'b0;
        check_state("midframe_reset");
        repeat (BIT * 2) @(negedge clk);
        send_char(8'h7E);
        check_state("after_reset_7e");
        drain("after_reset_drain");

        for (int n = 0; n < 6; n++) begin
            ch = 8'($urandom);
            data_out_ready = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, BIT)) @(negedge clk);
            send_char(ch);
        end
        data_out_ready = 1'b0;
        @(negedge clk);
        check_state("random_end");
        drain("random_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
